tank_pump_sequencer: RTL and testbench
======================================

TANK_PUMP_SEQUENCER -- requirements
Module: tank_pump_sequencer

Interface
REQ-001 Parameter NUM_PUMPS, default 4: number of pumps and level sensors, legal range 2..8.
REQ-002 Parameter MIN_ON_CYCLES, default 16: minimum cycles between a demand increase and any later decrease, legal range 1..255.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required per sensor bit, legal range 2..15; used only under PUMP_DEBOUNCE_EN.
REQ-004 Port clock, input, 1: single clock; all logic on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port enable, input, 1: high permits pumping; low forces all pumps off.
REQ-007 Port level_sensors, input, NUM_PUMPS: bit k is high when water reaches level k; bit 0 is the lowest level.
REQ-008 Port pumps, output, NUM_PUMPS: registered pump commands; bit k high means pump k is on.
REQ-009 Port active_count, output, clog2(NUM_PUMPS+1): registered number of pumps on (A).
REQ-010 Port lead_pump, output, clog2(NUM_PUMPS): registered index of the first pump in the rotation.
REQ-011 Port fault, output, 1: registered; high while in FAULT.
REQ-012 Port current_state, output, 2: registered FSM state, for debug.

Function
REQ-013 Sensor word L is valid when it is a thermometer code, i.e. for every k>0, L[k]=1 implies L[k-1]=1.
REQ-014 Demand D equals NUM_PUMPS minus popcount(L) when L is valid.
REQ-015 FSM states: IDLE (A=0), RUN (A>0), FAULT; current_state encodes IDLE=0, RUN=1, FAULT=2.
REQ-016 An invalid L in IDLE or RUN moves the FSM to FAULT on the same edge: A<=0, fault<=1, lead unchanged.
REQ-017 FAULT moves to IDLE on the first edge at which L is valid; A stays 0 and the hold counter clears on that edge.
REQ-018 When enable=0, A<=0 on the next edge regardless of the hold counter; in FAULT, fault handling takes priority over enable.
REQ-019 When D>A, the state is IDLE or RUN, and enable=1: A<=D on the next edge and the hold counter clears.
REQ-020 When D<A, the state is RUN, and enable=1: A<=D only if hold counter >= MIN_ON_CYCLES-1, after which the counter clears; otherwise A holds.
REQ-021 The hold counter increments in RUN while D<=A, saturates at MIN_ON_CYCLES-1, and clears on any change of A.
REQ-022 Any transition of A from nonzero to 0 outside FAULT advances lead by one: lead<=(lead+1) mod NUM_PUMPS, wrapping from NUM_PUMPS-1 to 0.
REQ-023 pumps has exactly A bits set, at indices lead, lead+1, ..., lead+A-1 mod NUM_PUMPS; pumps, A and lead update on the same edge.
REQ-024 Latency without debounce: L sampled at edge n is reflected on the outputs after edge n.
REQ-025 Simultaneous events, highest priority first: reset, fault, enable=0, demand change.

Reset
REQ-026 With reset=0 at a rising edge, the block sets pumps=0, A=0, lead=0, fault=0, state=IDLE, hold counter=0, and sets debouncer outputs to 0 when present.
REQ-027 Reset mid-operation (RUN or FAULT) takes effect on that edge, ignores MIN_ON_CYCLES, and does not advance lead.

Configuration
REQ-028 With macro PUMP_DEBOUNCE_EN defined, each sensor bit passes through a debouncer; a bit's output changes only after DEBOUNCE_CYCLES consecutive equal raw samples that differ from the current output, adding DEBOUNCE_CYCLES cycles of latency.
REQ-029 With PUMP_DEBOUNCE_EN undefined, raw level_sensors feeds the FSM directly, no debouncer logic is present, and latency follows REQ-024.

Structure
REQ-030 Shared package tank_pkg holds the state encoding constants, the NUM_PUMPS legal bounds, and the thermometer-validity and popcount helper functions.
REQ-031 The sensor debouncer is a sub-module, level_debouncer, instantiated once per sensor bit under PUMP_DEBOUNCE_EN.

Verification (NUM_PUMPS=4, MIN_ON_CYCLES=16, DEBOUNCE_CYCLES=4)
REQ-032 Reset held low with L=0000, then released -> during reset pumps=0000, lead=0, state=IDLE; pumps=1111 and A=4 on the first edge after release.
REQ-033 From A=4 just raised, L=0001 -> pumps stay 1111 for 15 edges, then pumps=0111 and A=3 on the 16th edge.
REQ-034 L=1111 from RUN with lead=0 -> pumps=0000, lead=1 on the next edge; then L=0011 -> pumps=0110.
REQ-035 L=0010 during RUN -> fault=1, pumps=0000, state=FAULT on the next edge; then L=0011 -> IDLE on one edge, pumps=0011 or rotated equivalent (lead unchanged) on the next.
REQ-036 enable dropped mid-RUN with lead=3 and A=2 -> pumps=0000 and lead=0 (wrap) on the next edge, hold counter ignored.
REQ-037 With PUMP_DEBOUNCE_EN defined, a 2-cycle glitch on bit 0 -> no output change; the same value held for 4 cycles -> outputs change 4 cycles later than without the macro.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared definitions for the tank pump sequencer: state encoding, pump-count bounds,
// and sensor-word helpers (thermometer validity, popcount) sized for the largest legal tank.
package tank_pkg;

  localparam int NUM_PUMPS_MIN = 2;
  localparam int NUM_PUMPS_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Callers zero-extend narrower sensor words; zero upper bits never break the code.
  function automatic logic is_thermometer(input logic [NUM_PUMPS_MAX-1:0] l);
    logic ok;
    ok = 1'b1;
    for (int k = 1; k < NUM_PUMPS_MAX; k++) begin
      if (l[k] && !l[k-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_PUMPS_MAX-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < NUM_PUMPS_MAX; k++) begin
      n = n + {3'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/level_debouncer.sv
// Single-bit debouncer: the output follows the raw input only after DEBOUNCE_CYCLES
// consecutive raw samples that all differ from the current output.
module level_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
      stable <= raw;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/tank_pump_sequencer.sv
// Tank pump sequencer: turns a thermometer-coded level word into a rotating set of pumps
// with a minimum-on hold. Define PUMP_DEBOUNCE_EN to debounce each sensor bit first.
module tank_pump_sequencer
  import tank_pkg::*;
#(
  parameter int NUM_PUMPS       = 4,
  parameter int MIN_ON_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_PUMPS-1:0]           level_sensors,
  output logic [NUM_PUMPS-1:0]           pumps,
  output logic [$clog2(NUM_PUMPS+1)-1:0] active_count,
  output logic [$clog2(NUM_PUMPS)-1:0]   lead_pump,
  output logic                           fault,
  output logic [1:0]                     current_state
);

  localparam int AW = $clog2(NUM_PUMPS + 1);
  localparam int LW = $clog2(NUM_PUMPS);
  localparam logic [7:0] HOLD_MAX = 8'(MIN_ON_CYCLES - 1);

  if (NUM_PUMPS < NUM_PUMPS_MIN || NUM_PUMPS > NUM_PUMPS_MAX ||
      MIN_ON_CYCLES < 1 || MIN_ON_CYCLES > 255 ||
      DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 15) begin : g_bad_params
    $error("tank_pump_sequencer: parameter out of legal range");
  end

  logic [NUM_PUMPS-1:0] level;

`ifdef PUMP_DEBOUNCE_EN
  for (genvar k = 0; k < NUM_PUMPS; k++) begin : g_debounce
    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .raw    (level_sensors[k]),
      .stable (level[k])
    );
  end
`else
  assign level = level_sensors;
`endif

  logic [NUM_PUMPS_MAX-1:0] level_ext;
  logic                     valid;
  logic [AW-1:0]            demand;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    level_ext                = '0;
    level_ext[NUM_PUMPS-1:0] = level;
  end

  assign valid  = is_thermometer(level_ext);
  assign demand = AW'(NUM_PUMPS) - AW'(popcount(level_ext));

  function automatic logic [LW-1:0] next_lead(input logic [LW-1:0] ld);
    return (ld == LW'(NUM_PUMPS - 1)) ? '0 : ld + LW'(1);
  endfunction

  // Pump i is on when its distance past the lead (mod NUM_PUMPS) is below the count.
  function automatic logic [NUM_PUMPS-1:0] rot_mask(input logic [AW-1:0] cnt,
                                                    input logic [LW-1:0] ld);
    logic [NUM_PUMPS-1:0] m;
    int off;
    m = '0;
    for (int i = 0; i < NUM_PUMPS; i++) begin
      off = i - int'(ld);
      if (off < 0) off = off + NUM_PUMPS;
      m[i] = (off < int'(cnt));
    end
    return m;
  endfunction

  state_t        state;
  logic [AW-1:0] count;
  logic [LW-1:0] lead;
  logic [7:0]    hold;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous,
  // so it sits inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      lead  <= '0;
      hold  <= '0;
      pumps <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        ST_FAULT: begin
          if (valid) begin
            state <= ST_IDLE;
            fault <= 1'b0;
            hold  <= '0;
          end
        end
        default: begin
          if (!valid) begin
            state <= ST_FAULT;
            fault <= 1'b1;
            count <= '0;
            pumps <= '0;
            hold  <= '0;
          end else if (!enable) begin
            state <= ST_IDLE;
            count <= '0;
            pumps <= '0;
            hold  <= '0;
            if (count != '0) lead <= next_lead(lead);
          end else if (demand > count) begin
            state <= ST_RUN;
            count <= demand;
            pumps <= rot_mask(demand, lead);
            hold  <= '0;
          end else if (demand < count) begin
            // Decreases wait for the minimum-on hold to expire.
            if (hold >= HOLD_MAX) begin
              count <= demand;
              pumps <= rot_mask(demand, lead);
              hold  <= '0;
              if (demand == '0) begin
                state <= ST_IDLE;
                lead  <= next_lead(lead);
              end
            end else begin
              hold <= hold + 8'd1;
            end
          end else if (state == ST_RUN && hold < HOLD_MAX) begin
            hold <= hold + 8'd1;
          end
        end
      endcase
    end
  end

  assign active_count  = count;
  assign lead_pump     = lead;
  assign current_state = state;

endmodule

// File: tb/tb_tank_pump_sequencer.sv
// Directed self-checking bench for tank_pump_sequencer (NUM_PUMPS=4, MIN_ON_CYCLES=16).
// With PUMP_DEBOUNCE_EN defined only the reset and debounce scenarios run.
module tb_tank_pump_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] level_sensors;
  logic [3:0] pumps;
  logic [2:0] active_count;
  logic [1:0] lead_pump;
  logic       fault;
  logic [1:0] current_state;

  int checks   = 0;
  int failures = 0;

  tank_pump_sequencer #(
    .NUM_PUMPS       (4),
    .MIN_ON_CYCLES   (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .level_sensors (level_sensors),
    .pumps         (pumps),
    .active_count  (active_count),
    .lead_pump     (lead_pump),
    .fault         (fault),
    .current_state (current_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; level_sensors = 4'b0000;
    tick(); tick();
    checks++; if (pumps !== 4'b0000) begin failures++; $display("FAIL reset_pumps got=%b exp=0000", pumps); end
    checks++; if (active_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", active_count); end
    checks++; if (lead_pump !== 2'd0) begin failures++; $display("FAIL reset_lead got=%0d exp=0", lead_pump); end
    checks++; if (current_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", current_state); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    reset = 1'b1;
    tick();
    checks++; if (pumps !== 4'b1111) begin failures++; $display("FAIL release_pumps got=%b exp=1111", pumps); end
    checks++; if (active_count !== 3'd4) begin failures++; $display("FAIL release_count got=%0d exp=4", active_count); end
    checks++; if (current_state !== 2'd1) begin failures++; $display("FAIL release_state got=%0d exp=1", current_state); end
  endtask

  task automatic test_min_on();
    level_sensors = 4'b0001;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (pumps !== 4'b1111) begin failures++; $display("FAIL min_on_hold edge=%0d got=%b exp=1111", i, pumps); end
    end
    tick();
    checks++; if (pumps !== 4'b0111) begin failures++; $display("FAIL min_on_drop_pumps got=%b exp=0111", pumps); end
    checks++; if (active_count !== 3'd3) begin failures++; $display("FAIL min_on_drop_count got=%0d exp=3", active_count); end
  endtask

  task automatic test_rotation();
    repeat (15) tick();
    level_sensors = 4'b1111;
    tick();
    checks++; if (pumps !== 4'b0000) begin failures++; $display("FAIL rot_off_pumps got=%b exp=0000", pumps); end
    checks++; if (lead_pump !== 2'd1) begin failures++; $display("FAIL rot_off_lead got=%0d exp=1", lead_pump); end
    checks++; if (current_state !== 2'd0) begin failures++; $display("FAIL rot_off_state got=%0d exp=0", current_state); end
    level_sensors = 4'b0011;
    tick();
    checks++; if (pumps !== 4'b0110) begin failures++; $display("FAIL rot_on_pumps got=%b exp=0110", pumps); end
    checks++; if (active_count !== 3'd2) begin failures++; $display("FAIL rot_on_count got=%0d exp=2", active_count); end
  endtask

  task automatic test_fault();
    level_sensors = 4'b0010;
    tick();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault_flag got=%b exp=1", fault); end
    checks++; if (pumps !== 4'b0000) begin failures++; $display("FAIL fault_pumps got=%b exp=0000", pumps); end
    checks++; if (current_state !== 2'd2) begin failures++; $display("FAIL fault_state got=%0d exp=2", current_state); end
    checks++; if (lead_pump !== 2'd1) begin failures++; $display("FAIL fault_lead got=%0d exp=1", lead_pump); end
    enable = 1'b0; level_sensors = 4'b0110;
    tick();
    checks++; if (current_state !== 2'd2) begin failures++; $display("FAIL fault_stay_state got=%0d exp=2", current_state); end
    enable = 1'b1; level_sensors = 4'b0011;
    tick();
    checks++; if (current_state !== 2'd0) begin failures++; $display("FAIL fault_exit_state got=%0d exp=0", current_state); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_exit_flag got=%b exp=0", fault); end
    checks++; if (pumps !== 4'b0000) begin failures++; $display("FAIL fault_exit_pumps got=%b exp=0000", pumps); end
    tick();
    checks++; if (pumps !== 4'b0110) begin failures++; $display("FAIL fault_resume_pumps got=%b exp=0110", pumps); end
    checks++; if (lead_pump !== 2'd1) begin failures++; $display("FAIL fault_resume_lead got=%0d exp=1", lead_pump); end
  endtask

  task automatic test_enable_wrap();
    enable = 1'b0; tick();
    checks++; if (lead_pump !== 2'd2) begin failures++; $display("FAIL en_off1_lead got=%0d exp=2", lead_pump); end
    enable = 1'b1; tick();
    checks++; if (pumps !== 4'b1100) begin failures++; $display("FAIL en_on1_pumps got=%b exp=1100", pumps); end
    enable = 1'b0; tick();
    checks++; if (lead_pump !== 2'd3) begin failures++; $display("FAIL en_off2_lead got=%0d exp=3", lead_pump); end
    enable = 1'b1; tick();
    checks++; if (pumps !== 4'b1001) begin failures++; $display("FAIL en_on2_pumps got=%b exp=1001", pumps); end
    checks++; if (active_count !== 3'd2) begin failures++; $display("FAIL en_on2_count got=%0d exp=2", active_count); end
    enable = 1'b0; tick();
    checks++; if (pumps !== 4'b0000) begin failures++; $display("FAIL en_wrap_pumps got=%b exp=0000", pumps); end
    checks++; if (lead_pump !== 2'd0) begin failures++; $display("FAIL en_wrap_lead got=%0d exp=0", lead_pump); end
    checks++; if (current_state !== 2'd0) begin failures++; $display("FAIL en_wrap_state got=%0d exp=0", current_state); end
  endtask

  task automatic test_demand_increase();
    enable = 1'b1; tick();
    checks++; if (pumps !== 4'b0011) begin failures++; $display("FAIL inc_start_pumps got=%b exp=0011", pumps); end
    level_sensors = 4'b0000; tick();
    checks++; if (pumps !== 4'b1111) begin failures++; $display("FAIL inc_up_pumps got=%b exp=1111", pumps); end
    checks++; if (active_count !== 3'd4) begin failures++; $display("FAIL inc_up_count got=%0d exp=4", active_count); end
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    checks++; if (lead_pump !== 2'd1) begin failures++; $display("FAIL mid_pre_lead got=%0d exp=1", lead_pump); end
    reset = 1'b0; tick();
    checks++; if (pumps !== 4'b0000) begin failures++; $display("FAIL mid_run_pumps got=%b exp=0000", pumps); end
    checks++; if (lead_pump !== 2'd0) begin failures++; $display("FAIL mid_run_lead got=%0d exp=0", lead_pump); end
    checks++; if (current_state !== 2'd0) begin failures++; $display("FAIL mid_run_state got=%0d exp=0", current_state); end
    reset = 1'b1; level_sensors = 4'b0100; tick();
    checks++; if (current_state !== 2'd2) begin failures++; $display("FAIL mid_fault_enter got=%0d exp=2", current_state); end
    reset = 1'b0; tick();
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mid_fault_flag got=%b exp=0", fault); end
    checks++; if (current_state !== 2'd0) begin failures++; $display("FAIL mid_fault_state got=%0d exp=0", current_state); end
    reset = 1'b1; level_sensors = 4'b0000; tick();
    checks++; if (pumps !== 4'b1111) begin failures++; $display("FAIL mid_restart_pumps got=%b exp=1111", pumps); end
  endtask

  task automatic test_debounce();
    repeat (20) tick();
    level_sensors = 4'b0001; tick(); tick();
    level_sensors = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (pumps !== 4'b1111) begin failures++; $display("FAIL deb_glitch edge=%0d got=%b exp=1111", i, pumps); end
    end
    level_sensors = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pumps !== 4'b1111) begin failures++; $display("FAIL deb_wait edge=%0d got=%b exp=1111", i, pumps); end
    end
    tick();
    checks++; if (pumps !== 4'b0111) begin failures++; $display("FAIL deb_change got=%b exp=0111", pumps); end
  endtask

  initial begin
    test_reset();
`ifdef PUMP_DEBOUNCE_EN
    test_debounce();
`else
    test_min_on();
    test_rotation();
    test_fault();
    test_enable_wrap();
    test_demand_increase();
    test_reset_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
